// File: rtl/ds_frame_writer_pkg.sv
// Shared definitions for the downsampler frame writer: geometry defaults,
// FSM state encoding and RGB565 field positions.
package ds_frame_writer_pkg;

   localparam int DS_OUT_W  = 128;
   localparam int DS_OUT_H  = 128;
   localparam int DS_PIX_W  = 16;
   localparam int DS_ADDR_W = 14;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } dsw_state_e;

   // RGB565 field positions, shared with the separate/compress stages
   localparam int RGB_R_MSB = 15;
   localparam int RGB_R_LSB = 11;
   localparam int RGB_G_MSB = 10;
   localparam int RGB_G_LSB = 5;
   localparam int RGB_B_MSB = 4;
   localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/ds_frame_writer_if.sv
// Pixel stream in / BRAM write port out of the frame writer.
// master = upstream pixel source side, slave = frame writer side.
interface ds_frame_writer_if #(
   parameter int PIX_W  = ds_frame_writer_pkg::DS_PIX_W,
   parameter int ADDR_W = ds_frame_writer_pkg::DS_ADDR_W
);
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [PIX_W-1:0]  bram_din;

   modport master (
      output pix_valid, pix_data,
      input  bram_we, bram_addr, bram_din
   );

   modport slave (
      input  pix_valid, pix_data,
      output bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/ds_frame_writer_xy_counter.sv
// Column/row position counter for the frame writer; col wraps into row,
// row wraps silently to 0 after the last pixel.
module ds_xy_counter #(
   parameter int OUT_W = 128,
   parameter int OUT_H = 128,
   localparam int CW   = $clog2(OUT_W),
   localparam int RW   = $clog2(OUT_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   logic col_end;
   assign col_end = (col == CW'(OUT_W - 1));
   assign last    = col_end && (row == RW'(OUT_H - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col_end) begin
            col <= '0;
            row <= row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ds_frame_writer.sv
// Frame writer: captures the qualified RGB565 stream into the output frame BRAM.
// Optional running pixel checksum output when DSW_CHECKSUM_EN is defined.
module ds_frame_writer
   import ds_frame_writer_pkg::*;
#(
   parameter int OUT_W  = DS_OUT_W,
   parameter int OUT_H  = DS_OUT_H,
   parameter int PIX_W  = DS_PIX_W,
   parameter int ADDR_W = DS_ADDR_W,
   localparam int CW    = $clog2(OUT_W),
   localparam int RW    = $clog2(OUT_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   ds_frame_writer_if.slave  bus,
   output logic [CW-1:0]     col,
   output logic [RW-1:0]     row,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow
`ifdef DSW_CHECKSUM_EN
   ,
   output logic [PIX_W-1:0]  checksum
`endif
);

   dsw_state_e        state;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [PIX_W-1:0]  din_q;
   logic              last;
   logic              start_ok;
   logic              accept;
   logic [ADDR_W-1:0] wr_addr;

   // start is honoured in IDLE and CAPTURE (restart); DONE ignores it
   assign start_ok = start && (state != ST_DONE);
   assign accept   = (state == ST_CAPTURE) && !start && bus.pix_valid;
   // power-of-two geometry: row*OUT_W+col is just the concatenation
   assign wr_addr  = {row, col};

   assign bus.bram_we   = we_q;
   assign bus.bram_addr = addr_q;
   assign bus.bram_din  = din_q;

   ds_xy_counter #(.OUT_W(OUT_W), .OUT_H(OUT_H)) u_xy (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_ok),
      .en   (accept),
      .col  (col),
      .row  (row),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         we_q       <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_CAPTURE;
                  busy     <= 1'b1;
                  overflow <= 1'b0;
               end else if (bus.pix_valid) begin
                  overflow <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (start) begin
                  overflow <= 1'b0;
               end else if (bus.pix_valid) begin
                  we_q   <= 1'b1;
                  addr_q <= wr_addr;
                  din_q  <= bus.pix_data;
                  if (last) begin
                     state      <= ST_DONE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               if (bus.pix_valid && !start) overflow <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DSW_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           checksum <= '0;
      else if (start_ok) checksum <= '0;
      else if (accept)   checksum <= checksum + bus.pix_data;
   end
`endif

endmodule
